// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: execute-stage issue controller for SimpleRISC ALU instructions.
// Accepts one instruction at a time, sequences the external ALU, writes back and maintains the E/GT flags.
module alu_issue_ctrl #(
    parameter int XLEN   = 32,
    parameter int NREG_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    output logic [NREG_W-1:0] rf_raddr1,
    output logic [NREG_W-1:0] rf_raddr2,
    input  logic [XLEN-1:0]   rf_rdata1,
    input  logic [XLEN-1:0]   rf_rdata2,
    output logic [XLEN-1:0]   alu_a,
    output logic [XLEN-1:0]   alu_b,
    output logic [4:0]        alu_control,
    input  logic [XLEN-1:0]   alu_result,
    output logic              wb_en,
    output logic [NREG_W-1:0] wb_addr,
    output logic [XLEN-1:0]   wb_data,
    output logic              flag_e,
    output logic              flag_gt,
    output logic              done,
    output logic              illegal
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DECODE,
        S_EXEC,
        S_WB
    } state_t;

    typedef enum logic [4:0] {
        OP_ADD = 5'd0,
        OP_SUB = 5'd1,
        OP_MUL = 5'd2,
        OP_DIV = 5'd3,
        OP_MOD = 5'd4,
        OP_CMP = 5'd5,
        OP_AND = 5'd6,
        OP_OR  = 5'd7,
        OP_NOT = 5'd8,
        OP_MOV = 5'd9,
        OP_LSL = 5'd10,
        OP_LSR = 5'd11,
        OP_ASR = 5'd12,
        OP_NOP = 5'd13
    } opcode_t;

    typedef enum logic [4:0] {
        ALU_ADD = 5'd0,
        ALU_SUB = 5'd1,
        ALU_MUL = 5'd2,
        ALU_DIV = 5'd3,
        ALU_MOD = 5'd4,
        ALU_CMP = 5'd5,
        ALU_AND = 5'd6,
        ALU_OR  = 5'd7,
        ALU_NOT = 5'd8,
        ALU_LSL = 5'd9,
        ALU_LSR = 5'd10,
        ALU_ASR = 5'd11
    } alu_op_t;

    state_t            state;
    state_t            state_nx;
    logic [31:0]       instr_q;
    logic              hs;

    logic [4:0]        op;
    logic              imm_sel;
    logic [1:0]        imm_mod;
    logic [15:0]       imm16;
    logic [NREG_W-1:0] rd;

    logic [XLEN-1:0]   op2;
    logic              op2_bad;

    alu_op_t           dec_ctrl;
    logic [XLEN-1:0]   dec_a;
    logic [XLEN-1:0]   dec_b;
    logic              dec_alu;
    logic              dec_write;
    logic              dec_cmp;
    logic              dec_ill;

    logic              write_q;
    logic              cmp_q;
    logic              ill_q;

    assign op        = instr_q[31:27];
    assign imm_sel   = instr_q[26];
    assign rd        = instr_q[22 +: NREG_W];
    assign imm_mod   = instr_q[17:16];
    assign imm16     = instr_q[15:0];
    assign rf_raddr1 = instr_q[18 +: NREG_W];
    assign rf_raddr2 = instr_q[14 +: NREG_W];

    assign hs = in_valid && in_ready;

    // Second operand: register or one of three immediate expansions.
    always_comb begin
        op2     = rf_rdata2;
        op2_bad = 1'b0;
        if (imm_sel) begin
            case (imm_mod)
                2'b00:   op2 = {{(XLEN-16){imm16[15]}}, imm16};
                2'b01:   op2 = {{(XLEN-16){1'b0}}, imm16};
                2'b10:   op2 = {imm16, {(XLEN-16){1'b0}}};
                default: begin
                    op2     = '0;
                    op2_bad = 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        dec_ctrl  = ALU_ADD;
        dec_a     = rf_rdata1;
        dec_b     = op2;
        dec_alu   = 1'b1;
        dec_write = 1'b1;
        dec_cmp   = 1'b0;
        dec_ill   = 1'b0;
        case (op)
            OP_ADD: dec_ctrl = ALU_ADD;
            OP_SUB: dec_ctrl = ALU_SUB;
            OP_MUL: dec_ctrl = ALU_MUL;
            OP_DIV: dec_ctrl = ALU_DIV;
            OP_MOD: dec_ctrl = ALU_MOD;
            OP_CMP: begin
                dec_ctrl  = ALU_CMP;
                dec_write = 1'b0;
                dec_cmp   = 1'b1;
            end
            OP_AND: dec_ctrl = ALU_AND;
            OP_OR:  dec_ctrl = ALU_OR;
            OP_NOT: begin
                dec_ctrl = ALU_NOT;
                dec_a    = op2;
                dec_b    = '0;
            end
            OP_MOV: begin
                dec_ctrl = ALU_ADD;
                dec_a    = '0;
            end
            OP_LSL: dec_ctrl = ALU_LSL;
            OP_LSR: dec_ctrl = ALU_LSR;
            OP_ASR: dec_ctrl = ALU_ASR;
            OP_NOP: begin
                dec_alu   = 1'b0;
                dec_write = 1'b0;
            end
            default: begin
                dec_alu   = 1'b0;
                dec_write = 1'b0;
                dec_ill   = 1'b1;
            end
        endcase
        // nop never consumes op2, so a reserved mod only faults real ALU ops
        if (op2_bad && op != OP_NOP) begin
            dec_alu   = 1'b0;
            dec_write = 1'b0;
            dec_cmp   = 1'b0;
            dec_ill   = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (in_valid) state_nx = S_DECODE;
            S_DECODE: state_nx = dec_alu ? S_EXEC : S_WB;
            S_EXEC:   state_nx = S_WB;
            S_WB:     state_nx = in_valid ? S_DECODE : S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready = !rst && (state == S_IDLE || state == S_WB);
        done     = (state == S_WB);
        wb_en    = (state == S_WB) && write_q;
        illegal  = (state == S_WB) && ill_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_q     <= '0;
            write_q     <= 1'b0;
            cmp_q       <= 1'b0;
            ill_q       <= 1'b0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_control <= '0;
            wb_addr     <= '0;
            wb_data     <= '0;
            flag_e      <= 1'b0;
            flag_gt     <= 1'b0;
        end else begin
            if (hs) begin
                instr_q <= in_instr;
            end
            if (state == S_DECODE) begin
                write_q <= dec_write;
                cmp_q   <= dec_cmp;
                ill_q   <= dec_ill;
                if (dec_alu) begin
                    alu_a       <= dec_a;
                    alu_b       <= dec_b;
                    alu_control <= dec_ctrl;
                    wb_addr     <= rd;
                end
            end
            if (state == S_EXEC) begin
                wb_data <= alu_result;
            end
            // cmp result is 0 (equal), 1 (greater) or all-ones (less)
            if (state == S_WB && cmp_q) begin
                flag_e  <= (wb_data == '0);
                flag_gt <= (wb_data == XLEN'(1));
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed bench with an ISA-level reference model checked every cycle,
// plus literal expectations on architectural results.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic [3:0]  rf_raddr1, rf_raddr2;
    logic [31:0] rf_rdata1, rf_rdata2;
    logic [31:0] alu_a, alu_b, alu_result, wb_data;
    logic [4:0]  alu_control;
    logic        wb_en, flag_e, flag_gt, done, illegal;
    logic [3:0]  wb_addr;

    always #5 clk = ~clk;

    alu_issue_ctrl #(.XLEN(32), .NREG_W(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control), .alu_result(alu_result),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .flag_e(flag_e), .flag_gt(flag_gt),
        .done(done), .illegal(illegal)
    );

    int checks = 0;
    int errors = 0;

    function automatic void check_word(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endfunction

    function automatic void check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b expected=%b", name, act, exp);
        end
    endfunction

    function automatic logic [31:0] rf_preset(input int i);
        case (i)
            0:       return 32'd0;
            2:       return 32'd7;
            3:       return 32'd5;
            default: return 32'(i) * 32'h101;
        endcase
    endfunction

    // Environment: register file (writes on the edge ending WB) and combinational ALU.
    logic [31:0] rf [16];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) rf[i] <= rf_preset(i);
        end else if (wb_en) begin
            rf[wb_addr] <= wb_data;
        end
    end
    assign rf_rdata1 = rf[rf_raddr1];
    assign rf_rdata2 = rf[rf_raddr2];

    always_comb begin
        alu_result = '0;
        case (alu_control)
            5'd0:  alu_result = alu_a + alu_b;
            5'd1:  alu_result = alu_a - alu_b;
            5'd2:  alu_result = alu_a * alu_b;
            5'd3:  alu_result = (alu_b == 0) ? 32'd0 : alu_a / alu_b;
            5'd4:  alu_result = (alu_b == 0) ? 32'd0 : alu_a % alu_b;
            5'd5:  alu_result = ($signed(alu_a) == $signed(alu_b)) ? 32'd0 :
                                ($signed(alu_a) > $signed(alu_b)) ? 32'd1 : 32'hFFFF_FFFF;
            5'd6:  alu_result = alu_a & alu_b;
            5'd7:  alu_result = alu_a | alu_b;
            5'd8:  alu_result = ~alu_a;
            5'd9:  alu_result = alu_a << alu_b[4:0];
            5'd10: alu_result = alu_a >> alu_b[4:0];
            5'd11: alu_result = $signed(alu_a) >>> alu_b[4:0];
            default: alu_result = '0;
        endcase
    end

    // Reference model: cycles remaining for the in-flight instruction and its architectural effect.
    logic [31:0] m_rf [16];
    int          busy = 0;
    logic        cur_wen, cur_ill, cur_cmp, cur_e, cur_gt;
    logic [3:0]  cur_rd;
    logic [31:0] cur_res;
    logic [4:0]  pend_ctrl, m_ctrl;
    logic [31:0] pend_a, pend_b, m_a, m_b;
    logic        m_e, m_gt;
    logic        exp_ready, retiring;

    function automatic void model_accept(input logic [31:0] w);
        logic [4:0]  op;
        logic        isel;
        logic [1:0]  md;
        logic [15:0] imm;
        logic [31:0] r1, o2;
        op   = w[31:27];
        isel = w[26];
        md   = w[17:16];
        imm  = w[15:0];
        r1   = m_rf[w[21:18]];
        o2   = m_rf[w[17:14]];
        if (isel) begin
            if (md == 2'd0)      o2 = {{16{imm[15]}}, imm};
            else if (md == 2'd1) o2 = {16'h0, imm};
            else                 o2 = {imm, 16'h0};
        end
        cur_rd = w[25:22]; cur_wen = 1'b0; cur_ill = 1'b0; cur_cmp = 1'b0;
        cur_res = '0; cur_e = 1'b0; cur_gt = 1'b0;
        if (op > 5'd13 || (isel && md == 2'd3 && op != 5'd13)) begin
            cur_ill = 1'b1;
            busy = 2;
        end else if (op == 5'd13) begin
            busy = 2;
        end else begin
            busy      = 3;
            cur_wen   = (op != 5'd5);
            pend_ctrl = (op <= 5'd8) ? op : (op == 5'd9) ? 5'd0 : op - 5'd1;
            pend_a    = (op == 5'd8) ? o2 : (op == 5'd9) ? 32'd0 : r1;
            pend_b    = (op == 5'd8) ? 32'd0 : o2;
            case (op)
                5'd0:  cur_res = r1 + o2;
                5'd1:  cur_res = r1 - o2;
                5'd2:  cur_res = r1 * o2;
                5'd3:  cur_res = (o2 == 0) ? 32'd0 : r1 / o2;
                5'd4:  cur_res = (o2 == 0) ? 32'd0 : r1 % o2;
                5'd5:  begin
                    cur_cmp = 1'b1;
                    cur_e   = (r1 == o2);
                    cur_gt  = ($signed(r1) > $signed(o2));
                end
                5'd6:  cur_res = r1 & o2;
                5'd7:  cur_res = r1 | o2;
                5'd8:  cur_res = ~o2;
                5'd9:  cur_res = o2;
                5'd10: cur_res = r1 << o2[4:0];
                5'd11: cur_res = r1 >> o2[4:0];
                default: cur_res = $signed(r1) >>> o2[4:0];
            endcase
        end
    endfunction

    int          cyc = 0;
    int          n_done = 0, n_wb = 0, n_ill = 0;
    int          done_cyc [$];
    logic [31:0] last_wb_data = '0, last_a = '0, last_b = '0;
    logic [4:0]  last_ctrl = '0;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            check_bit("rst_in_ready", in_ready, 1'b0);
            check_bit("rst_wb_en", wb_en, 1'b0);
            check_bit("rst_done", done, 1'b0);
            check_bit("rst_illegal", illegal, 1'b0);
            check_bit("rst_flag_e", flag_e, 1'b0);
            check_bit("rst_flag_gt", flag_gt, 1'b0);
            check_word("rst_alu_a", alu_a, 32'd0);
            check_word("rst_alu_b", alu_b, 32'd0);
            check_word("rst_alu_control", 32'(alu_control), 32'd0);
            check_word("rst_wb_data", wb_data, 32'd0);
            check_word("rst_wb_addr", 32'(wb_addr), 32'd0);
            busy = 0; m_e = 1'b0; m_gt = 1'b0;
            m_ctrl = '0; m_a = '0; m_b = '0;
            cur_wen = 1'b0; cur_ill = 1'b0; cur_cmp = 1'b0;
            for (int i = 0; i < 16; i++) m_rf[i] = rf_preset(i);
        end else begin
            exp_ready = (busy <= 1);
            retiring  = (busy == 1);
            check_bit("in_ready", in_ready, exp_ready);
            check_bit("done", done, retiring);
            check_bit("wb_en", wb_en, retiring && cur_wen);
            check_bit("illegal", illegal, retiring && cur_ill);
            if (retiring && cur_wen) begin
                check_word("wb_addr", 32'(wb_addr), 32'(cur_rd));
                check_word("wb_data", wb_data, cur_res);
            end
            check_bit("flag_e", flag_e, m_e);
            check_bit("flag_gt", flag_gt, m_gt);
            check_word("alu_control", 32'(alu_control), 32'(m_ctrl));
            check_word("alu_a", alu_a, m_a);
            check_word("alu_b", alu_b, m_b);
            if (done) begin
                n_done++;
                done_cyc.push_back(cyc);
                last_ctrl = alu_control; last_a = alu_a; last_b = alu_b;
            end
            if (wb_en) begin
                n_wb++;
                last_wb_data = wb_data;
            end
            if (illegal) n_ill++;
            if (busy == 3) begin
                m_ctrl = pend_ctrl; m_a = pend_a; m_b = pend_b;
            end
            if (retiring) begin
                if (cur_wen) m_rf[cur_rd] = cur_res;
                if (cur_cmp) begin
                    m_e = cur_e; m_gt = cur_gt;
                end
            end
            if (busy > 0) busy--;
            if (in_valid && exp_ready) model_accept(in_instr);
        end
    end

    function automatic logic [31:0] enc_r(input int op, input int rd, input int rs1, input int rs2);
        return {op[4:0], 1'b0, rd[3:0], rs1[3:0], rs2[3:0], 14'd0};
    endfunction

    function automatic logic [31:0] enc_i(input int op, input int rd, input int rs1, input int md, input int imm);
        return {op[4:0], 1'b1, rd[3:0], rs1[3:0], md[1:0], imm[15:0]};
    endfunction

    task automatic issue(input logic [31:0] w);
        logic ok;
        ok = 1'b0;
        in_instr = w;
        in_valid = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout actual=no_handshake expected=handshake instr=%h", w);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_instr = w ^ 32'hDEAD_BEEF;
    endtask

    task automatic run(input logic [31:0] w);
        issue(w);
        repeat (4) @(posedge clk);
        #1;
    endtask

    int n0, w0, i0;

    initial begin
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        run(enc_r(0, 1, 2, 3));
        check_word("add_ctrl", 32'(last_ctrl), 32'd0);
        check_word("add_a", last_a, 32'd7);
        check_word("add_b", last_b, 32'd5);
        check_word("add_wb_data", last_wb_data, 32'd12);
        check_word("add_rf1", rf[1], 32'd12);
        check_word("model_rf1", m_rf[1], 32'd12);

        run(enc_i(9, 4, 0, 0, 16'hFFFF));
        check_word("mov_sext", rf[4], 32'hFFFF_FFFF);
        check_word("mov_sext_a", last_a, 32'd0);
        run(enc_i(9, 4, 0, 1, 16'hFFFF));
        check_word("mov_zext", rf[4], 32'h0000_FFFF);
        run(enc_i(9, 4, 0, 2, 16'hFFFF));
        check_word("mov_hi", rf[4], 32'hFFFF_0000);
        w0 = n_wb; i0 = n_ill;
        run(enc_i(9, 4, 0, 3, 16'hFFFF));
        check_word("mov_mod3_illegal", 32'(n_ill - i0), 32'd1);
        check_word("mov_mod3_no_wb", 32'(n_wb - w0), 32'd0);
        check_word("mov_mod3_rf4", rf[4], 32'hFFFF_0000);

        run(enc_i(9, 6, 0, 0, 9));
        run(enc_i(9, 7, 0, 0, 3));
        w0 = n_wb;
        run(enc_i(5, 0, 6, 0, 9));
        check_bit("cmp99_e", flag_e, 1'b1);
        check_bit("cmp99_gt", flag_gt, 1'b0);
        check_bit("model_cmp99_e", m_e, 1'b1);
        run(enc_i(5, 0, 6, 0, 3));
        check_bit("cmp93_e", flag_e, 1'b0);
        check_bit("cmp93_gt", flag_gt, 1'b1);
        run(enc_r(5, 0, 7, 6));
        check_bit("cmp39_e", flag_e, 1'b0);
        check_bit("cmp39_gt", flag_gt, 1'b0);
        check_word("cmp_no_wb", 32'(n_wb - w0), 32'd0);
        run(enc_i(5, 0, 6, 0, 9));
        run(enc_r(0, 1, 2, 3));
        check_bit("hold_e", flag_e, 1'b1);
        check_bit("hold_gt", flag_gt, 1'b0);

        run(enc_i(9, 2, 0, 0, 1));
        run(enc_i(10, 1, 2, 0, 4));
        check_word("lsl_ctrl", 32'(last_ctrl), 32'h09);
        check_word("lsl_wb_data", last_wb_data, 32'd16);

        run(enc_i(8, 5, 0, 0, 0));
        check_word("not_a", last_a, 32'd0);
        check_word("not_ctrl", 32'(last_ctrl), 32'h08);
        check_word("not_wb_data", last_wb_data, 32'hFFFF_FFFF);

        n0 = n_done; w0 = n_wb;
        run(enc_r(13, 0, 0, 0));
        check_word("nop_done", 32'(n_done - n0), 32'd1);
        check_word("nop_no_wb", 32'(n_wb - w0), 32'd0);

        n0 = done_cyc.size();
        issue(enc_r(0, 8, 6, 7));
        issue(enc_r(1, 9, 6, 7));
        issue(enc_r(3, 10, 6, 0));
        repeat (4) @(posedge clk);
        #1;
        check_word("b2b_count", 32'(done_cyc.size() - n0), 32'd3);
        if (done_cyc.size() >= n0 + 3) begin
            check_word("b2b_gap1", 32'(done_cyc[n0+1] - done_cyc[n0]), 32'd3);
            check_word("b2b_gap2", 32'(done_cyc[n0+2] - done_cyc[n0+1]), 32'd3);
        end
        check_word("b2b_add", rf[8], 32'd12);
        check_word("b2b_sub", rf[9], 32'd6);
        check_word("div_by_zero", rf[10], 32'd0);

        i0 = n_ill;
        run(enc_r(14, 11, 1, 1));
        run(enc_r(31, 11, 1, 1));
        check_word("bad_opcode_illegal", 32'(n_ill - i0), 32'd2);
        check_word("bad_opcode_rf11", rf[11], 32'h0000_0B0B);

        n0 = n_done; w0 = n_wb;
        issue(enc_r(0, 12, 6, 7));
        @(posedge clk);
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check_word("rst_exec_no_done", 32'(n_done - n0), 32'd0);
        check_word("rst_exec_no_wb", 32'(n_wb - w0), 32'd0);
        check_word("rst_exec_rf12", rf[12], 32'h0000_0C0C);

        run(enc_r(0, 1, 2, 3));
        check_word("recover_add", rf[1], 32'd12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Execute-stage controller that sits on the producer side of the ALU. It accepts one 32-bit SimpleRISC instruction at a time over a valid/ready handshake and reads its source registers. It drives `alu_control`, `a` and `b` into the ALU, captures the ALU result, writes it back to the register file, and maintains the architectural E/GT flags. It is a multi-cycle FSM that owns all opcode-to-ALU-code translation.

## Interface
Parameters:
- `XLEN`, 32: datapath width; only 32 is supported.
- `NREG_W`, 4: register address width (16 registers).

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  instruction offered.
- `in_ready`  out  1  block can accept an instruction.
- `in_instr`  in  32  SimpleRISC instruction word.
- `rf_raddr1` / `rf_raddr2`  out  4 each  register file read addresses (rs1, rs2).
- `rf_rdata1` / `rf_rdata2`  in  32 each  combinational read data.
- `alu_a` / `alu_b`  out  32 each  registered ALU operands.
- `alu_control`  out  5  registered ALU operation code.
- `alu_result`  in  32  combinational ALU result.
- `wb_en`  out  1  one-cycle write strobe.
- `wb_addr`  out  4  destination register.
- `wb_data`  out  32  writeback value.
- `flag_e` / `flag_gt`  out  1 each  architectural flags.
- `done`  out  1  one-cycle retire pulse.
- `illegal`  out  1  one-cycle pulse for an unsupported opcode.

## Operation
Instruction fields:
- `op` = [31:27]
- `I` = [26]
- `rd` = [25:22]
- `rs1` = [21:18]
- `rs2` = [17:14]
- `mod` = [17:16]
- `imm16` = [15:0]

Second operand `op2`:
- `I`=0: `rf_rdata2`.
- `I`=1, `mod`=00: sign-extended `imm16`.
- `I`=1, `mod`=01: zero-extended `imm16`.
- `I`=1, `mod`=10: `{imm16,16'h0}`.
- `I`=1, `mod`=11: illegal.

Opcode map (op → `alu_control`, `a`, `b`):
- add 00000 → 00000, rs1, op2
- sub 00001 → 00001, rs1, op2
- mul 00010 → 00010, rs1, op2
- div 00011 → 00011, rs1, op2
- mod 00100 → 00100, rs1, op2
- cmp 00101 → 00101, rs1, op2; no writeback
- and 00110 → 00110, rs1, op2
- or 00111 → 00111, rs1, op2
- not 01000 → 01000, a=op2, b=0
- mov 01001 → 00000, a=0, b=op2
- lsl 01010 → 01001, rs1, op2
- lsr 01011 → 01010, rs1, op2
- asr 01100 → 01011, rs1, op2
- nop 01101 → no ALU use, no writeback, retires
- op ≥ 01110 → illegal

FSM states:
- IDLE: `in_ready`=1. On `in_valid`: latch the instruction, go to DECODE.
- DECODE: drive `rf_raddr1`/`rf_raddr2` from the latched word. Register `alu_a`, `alu_b`, `alu_control` per the map. Go to EXEC.
- EXEC: ALU inputs are stable. Register `alu_result` into `wb_data`. Go to WB.
- WB:
  - Pulse `done`.
  - Pulse `wb_en` for writing opcodes.
  - For cmp, update the flags from the captured result: 0 → E=1, GT=0; 1 → E=0, GT=1; all-ones → E=0, GT=0.
  - `in_ready`=1. A handshake here latches the next instruction and goes to DECODE; otherwise go to IDLE.
- Illegal or nop: DECODE goes directly to WB.
  - Illegal: `illegal`=1, `done`=1, no writeback, no flag change, ALU registers unchanged.
  - Nop: `done`=1 only.

Rules:
- Flags change only on cmp and hold otherwise.
- Divide/modulo by zero is not trapped; the ALU's 0 is written back.
- The instruction word is captured only on handshake. `in_instr` changes at other times are ignored.

## Timing
- Reset values: state IDLE; `alu_a`, `alu_b`, `alu_control`, `wb_data`, `wb_addr` = 0; `wb_en`, `done`, `illegal`, `flag_e`, `flag_gt` = 0.
- `in_ready` = 0 while `rst` is high.
- `rst` mid-instruction: the instruction is abandoned, with no `wb_en`, `done` or flag update.
- Latency: handshake at edge T → `wb_en`/`done` high during cycle T+3.
- Throughput: back-to-back issue sustains one instruction per 3 cycles; from IDLE, the first takes 3.
- `wb_en`, `done`, `illegal` are high exactly one cycle.
- `wb_addr`/`wb_data` are valid while `wb_en` is high.
- The register file must write on the edge ending WB. A following instruction reading that register is in DECODE after that edge, so no forwarding is needed.

## Test plan
- `add r1,r2,r3`, with r2=7, r3=5 → `alu_control`=00000, `a`=7, `b`=5; `wb_en` at T+3 with `wb_addr`=1, `wb_data`=12.
- `mov r4,#0xFFFF` for each `mod`:
  - 00 → `wb_data`=0xFFFFFFFF.
  - 01 → `wb_data`=0x0000FFFF.
  - 10 → `wb_data`=0xFFFF0000.
  - 11 → `illegal` pulse, no `wb_en`.
- `cmp` with operand pairs (9,9), (9,3), (3,9) → flags (E,GT) = (1,0), (0,1), (0,0) respectively. No `wb_en` for any of them. Flags then hold across a following `add`.
- `lsl r1,r2,#4` with r2=1 → `alu_control`=01001, `wb_data`=16.
- `not r5,#0`, sign-extended → `alu_a`=0, `wb_data`=0xFFFFFFFF.
- Back-to-back `in_valid` with 3 instructions → `in_ready` high only in IDLE/WB, `done` pulses 3 cycles apart. Separately, assert `rst` during EXEC → no `wb_en`, all outputs return to reset values.
